cpu_multiply_issue: RTL and testbench

//  RV32M multiply sequencer between the execute stage and the CPU_Multiply core.

---
 rtl/cpu_mul_pkg.sv | 21 ++
 rtl/cpu_mul_sign_fix.sv | 31 +++
 rtl/cpu_multiply_issue.sv | 142 ++++++++++++++
 tb/tb_cpu_multiply_issue.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_mul_pkg.sv
// Shared types for the RV32M multiply sequencer: funct3 encodings, FSM states, operand width.
// No logic; imported by the sequencer top and its sign-fix helper.
package cpu_mul_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_FIXUP,
        ST_OUTPUT
    } state_e;

endpackage

// File: rtl/cpu_mul_sign_fix.sv
// Operand magnitude conversion on entry and conditional two's-complement negate of the raw product.
// Latency: purely combinational. Backpressure: none, no state.
module cpu_mul_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   op1,
    input  logic [XLEN-1:0]   op2,
    input  logic              op1_signed,
    input  logic              op2_signed,
    output logic [XLEN-1:0]   mag1,
    output logic [XLEN-1:0]   mag2,
    output logic              negate,
    input  logic [2*XLEN-1:0] raw,
    input  logic              neg_en,
    output logic [2*XLEN-1:0] product
);

    logic neg1;
    logic neg2;

    // The most negative value maps onto itself, which reads correctly as an unsigned magnitude.
    always_comb begin
        neg1    = op1_signed & op1[XLEN-1];
        neg2    = op2_signed & op2[XLEN-1];
        mag1    = neg1 ? (~op1 + 1'b1) : op1;
        mag2    = neg2 ? (~op2 + 1'b1) : op2;
        negate  = neg1 ^ neg2;
        product = neg_en ? (~raw + 1'b1) : raw;
    end

endmodule

// File: rtl/cpu_multiply_issue.sv
// RV32M multiply sequencer: decode, magnitude issue to the unsigned core, sign fixup, rd writeback.
// Latency: accept A, latch A+1, core ready R, o_valid R+2 (A+2 on a reuse hit when CPU_MUL_REUSE_EN).
// Backpressure: o_valid/o_rd/o_result held until i_wb_ready; no new accept until back in IDLE.
module cpu_multiply_issue #(
    parameter int XLEN = cpu_mul_pkg::XLEN
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_request,
    input  logic [2:0]        i_funct3,
    input  logic [4:0]        i_rd,
    input  logic [XLEN-1:0]   i_op1,
    input  logic [XLEN-1:0]   i_op2,
    output logic              o_accept,
    output logic              o_illegal,
    output logic              o_mul_latch,
    output logic              o_mul_signed,
    output logic [XLEN-1:0]   o_mul_op1,
    output logic [XLEN-1:0]   o_mul_op2,
    input  logic              i_mul_ready,
    input  logic [2*XLEN-1:0] i_mul_result,
    output logic              o_valid,
    output logic [4:0]        o_rd,
    output logic [XLEN-1:0]   o_result,
    input  logic              i_wb_ready
);

    import cpu_mul_pkg::*;

    state_e            state_q, state_d;
    funct3_e           funct3_q;
    logic              neg_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   op1_q, op2_q, result_q;
    logic [2*XLEN-1:0] raw_q, product;
    logic [XLEN-1:0]   mag1, mag2;
    logic              negate, reuse_hit;
    logic              accept, illegal, latch, valid, capture;

    cpu_mul_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .op1        (i_op1),
        .op2        (i_op2),
        .op1_signed ((i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU)),
        .op2_signed (i_funct3 == F3_MULH),
        .mag1       (mag1),
        .mag2       (mag2),
        .negate     (negate),
        .raw        (raw_q),
        .neg_en     (neg_q),
        .product    (product)
    );

`ifdef CPU_MUL_REUSE_EN
    logic reuse_vld_q;

    assign reuse_hit = reuse_vld_q && (mag1 == op1_q) && (mag2 == op2_q);

    // Stored product is only trustworthy while the held magnitudes still belong to it.
    always_ff @(posedge i_clock) begin
        if (i_reset)
            reuse_vld_q <= 1'b0;
        else if (capture)
            reuse_vld_q <= 1'b1;
        else if (accept && !reuse_hit)
            reuse_vld_q <= 1'b0;
    end
`else
    assign reuse_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        illegal = 1'b0;
        latch   = 1'b0;
        valid   = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_request && !i_reset) begin
                    if (i_funct3[2]) begin
                        illegal = 1'b1;
                    end else if (!i_mul_ready) begin
                        accept  = 1'b1;
                        state_d = reuse_hit ? ST_FIXUP : ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                latch = 1'b1;
                if (i_mul_ready) begin
                    capture = 1'b1;
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: state_d = ST_OUTPUT;
            ST_OUTPUT: begin
                valid = 1'b1;
                if (i_wb_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            funct3_q <= F3_MUL;
            neg_q    <= 1'b0;
            rd_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            raw_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                funct3_q <= funct3_e'(i_funct3);
                neg_q    <= negate;
                rd_q     <= i_rd;
                op1_q    <= mag1;
                op2_q    <= mag2;
            end
            if (capture)
                raw_q <= i_mul_result;
            if (state_q == ST_FIXUP)
                result_q <= (funct3_q == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        end
    end

    assign o_accept     = accept;
    assign o_illegal    = illegal;
    assign o_mul_latch  = latch;
    assign o_mul_signed = 1'b0;
    assign o_mul_op1    = op1_q;
    assign o_mul_op2    = op2_q;
    assign o_valid      = valid;
    assign o_rd         = rd_q;
    assign o_result     = result_q;

endmodule

// File: tb/tb_cpu_multiply_issue.sv
// Directed bench for cpu_multiply_issue with a small unsigned multiplier core model.
module tb_cpu_multiply_issue;

`ifdef CPU_MUL_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [2:0]  funct3;
    logic [4:0]  rd_in;
    logic [31:0] op1, op2;
    logic        accept, illegal, mul_latch, mul_signed;
    logic [31:0] mul_op1, mul_op2;
    logic        mul_ready;
    logic [63:0] mul_result;
    logic        valid;
    logic [4:0]  rd_out;
    logic [31:0] result;
    logic        wb_rdy;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int core_cnt;

    cpu_multiply_issue dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_request    (req),
        .i_funct3     (funct3),
        .i_rd         (rd_in),
        .i_op1        (op1),
        .i_op2        (op2),
        .o_accept     (accept),
        .o_illegal    (illegal),
        .o_mul_latch  (mul_latch),
        .o_mul_signed (mul_signed),
        .o_mul_op1    (mul_op1),
        .o_mul_op2    (mul_op2),
        .i_mul_ready  (mul_ready),
        .i_mul_result (mul_result),
        .o_valid      (valid),
        .o_rd         (rd_out),
        .o_result     (result),
        .i_wb_ready   (wb_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: ready three cycles after latch rises, held until latch drops.
    always @(posedge clk) begin
        if (rst || !mul_latch) begin
            mul_ready <= 1'b0;
            core_cnt  <= 0;
            if (rst) mul_result <= '0;
        end else if (!mul_ready) begin
            core_cnt <= core_cnt + 1;
            if (core_cnt == 2) begin
                mul_ready  <= 1'b1;
                mul_result <= {32'd0, mul_op1} * {32'd0, mul_op2};
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                          input int stall, input bit exp_reuse);
        int a_cyc, r_cyc, v_cyc, k;
        bit seen_latch, stable;
        logic latch_r1;
        @(negedge clk);
        req = 1'b1; funct3 = f3; rd_in = rd; op1 = a; op2 = b;
        wb_rdy = (stall == 0);
        #1;
        k = 0;
        while (!accept && k < 20) begin
            @(negedge clk); #1; k++;
        end
        chk({tag, "/accept"}, accept, 1);
        a_cyc = cyc;
        @(posedge clk); #1 req = 1'b0;
        r_cyc = -1; v_cyc = -1; seen_latch = 0; latch_r1 = 1'bx;
        for (int i = 0; i < 40 && v_cyc < 0; i++) begin
            @(negedge clk);
            if (mul_latch) seen_latch = 1;
            if (r_cyc >= 0 && cyc == r_cyc + 1) latch_r1 = mul_latch;
            if (mul_latch && mul_ready && r_cyc < 0) r_cyc = cyc;
            if (valid) v_cyc = cyc;
        end
        chk({tag, "/valid_seen"}, v_cyc >= 0, 1);
        chk({tag, "/result"}, result, exp);
        chk({tag, "/rd"}, rd_out, rd);
        if (exp_reuse) begin
            chk({tag, "/no_latch"}, seen_latch, 0);
            chk({tag, "/lat_a2"}, v_cyc - a_cyc, 2);
        end else begin
            chk({tag, "/latch_drop"}, latch_r1, 0);
            chk({tag, "/lat_r2"}, v_cyc - r_cyc, 2);
        end
        if (stall > 0) begin
            req = 1'b1; funct3 = 3'b000; rd_in = 5'd30; op1 = 32'd7; op2 = 32'd9;
            stable = 1;
            repeat (stall) begin
                @(negedge clk); #1;
                if (!valid || result !== exp || rd_out !== rd || accept) stable = 0;
            end
            chk({tag, "/stall_stable"}, stable, 1);
            req = 1'b0;
            wb_rdy = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, "/handoff"}, valid, 0);
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1; req = 1'b0; funct3 = 3'b000; rd_in = '0; op1 = '0; op2 = '0; wb_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset/flags", {accept, illegal, mul_latch, valid, mul_signed}, 5'b0);
        chk("reset/rd", rd_out, 0);
        chk("reset/result", result, 0);
        chk("reset/ops", {mul_op1, mul_op2}, 64'd0);

        run_op("mul_111x222",  3'b000, 5'd5, 32'd111,        32'd222,        32'd24642,      0, 0);
        run_op("mulh_m1xm1",   3'b001, 5'd6, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  0, 0);
        run_op("mul_m1xm1",    3'b000, 5'd7, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  0, 0);
        run_op("mulhsu_m1",    3'b010, 5'd8, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 0);
        run_op("mulhu_m1",     3'b011, 5'd9, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  0, 0);
        run_op("mulh_min",     3'b001, 5'd10, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000,  0, 0);
        run_op("mulh_m2x3",    3'b001, 5'd11, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF,  0, 0);
        run_op("mul_m2x3_stl", 3'b000, 5'd12, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFA,  5, 0);

        @(negedge clk);
        req = 1'b1; funct3 = 3'b101; rd_in = 5'd13; op1 = 32'd1; op2 = 32'd2;
        #1;
        chk("illegal/pulse", {illegal, accept}, 2'b10);
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("illegal/drop", {illegal, mul_latch, valid}, 3'b0);

        // Abort an operation while the core is still working on it.
        @(negedge clk);
        req = 1'b1; funct3 = 3'b000; rd_in = 5'd14; op1 = 32'd1234; op2 = 32'd5678;
        #1;
        chk("rst/accept", accept, 1);
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        chk("rst/latch_pre", mul_latch, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst/flags", {accept, illegal, mul_latch, valid}, 4'b0);
        chk("rst/data", {rd_out, result, mul_op1}, 69'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        chk("rst/no_valid", seen, 0);

        run_op("mul_555x666",  3'b000, 5'd15, 32'd555, 32'd666, 32'd369630, 0, 0);
        run_op("reuse_mulh",   3'b001, 5'd16, 32'd111, 32'd222, 32'd0,      0, 0);
        run_op("reuse_mul",    3'b000, 5'd17, 32'd111, 32'd222, 32'd24642,  0, REUSE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
